// File: rtl/dbus_sram_responder_pkg.sv
// Shared bus types for the data-bus SRAM responder: request/response structs,
// access sizes, responder FSM states and the size-alignment helper.
package dbus_sram_responder_pkg;

  localparam int WORD_BYTES = 8;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  // An access is aligned when the address is a multiple of its byte width.
  function automatic logic msize_align_ok(input logic [63:0] addr, input msize_t size);
    case (size)
      MSIZE1:  return 1'b1;
      MSIZE2:  return addr[0] == 1'b0;
      MSIZE4:  return addr[1:0] == 2'b00;
      default: return addr[2:0] == 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/dbus_sram_responder_array.sv
// Word-organised DEPTH x 64 storage with per-byte write enables,
// an asynchronous read port and one synchronous write port sharing an index.
module dbus_sram_array
  import dbus_sram_responder_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  logic [7:0]               i_strobe,
  input  logic [63:0]              i_wdata,
  output logic [63:0]              o_rdata
);

  logic [63:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (i_strobe[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dbus_sram_responder.sv
// Memory side of the dbus handshake backed by an SRAM with programmable latency.
// Optional macro DBUS_RAND_LAT_EN adds 0..3 cycles of LFSR-driven extra latency.
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err,
  output logic       busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 4);

  resp_state_t      r_state;
  resp_state_t      w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_load;
  logic [63:0]      r_addr;
  logic [63:0]      r_data;
  msize_t           r_size;
  logic [7:0]       r_strobe;
  logic [60:0]      w_word;
  logic [IDX_W-1:0] w_idx;
  logic             w_oor;
  logic             w_mis;
  logic             w_err;
  logic             w_we;
  logic [63:0]      w_rdata;

`ifdef DBUS_RAND_LAT_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= 16'hACE1;
    else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_load = CNT_W'(LATENCY) + CNT_W'(r_lfsr[1:0]);
`else
  assign w_load = CNT_W'(LATENCY);
`endif

  // BASE_ADDR is DEPTH*8 aligned, so the word offset needs only the upper address bits.
  assign w_word = r_addr[63:3] - BASE_ADDR[63:3];
  assign w_idx  = w_word[IDX_W-1:0];
  assign w_oor  = (r_addr < BASE_ADDR) || (w_word >= 61'(DEPTH));
  assign w_mis  = !msize_align_ok(r_addr, r_size);
  assign w_err  = w_oor || w_mis;
  assign w_we   = (r_state == RESP) && (r_strobe != 8'h00) && !w_err && !reset;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (dreq.valid) w_next = (w_load == '0) ? RESP : WAIT;
      WAIT:    if (r_cnt <= CNT_W'(1)) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_size   <= MSIZE1;
      r_strobe <= '0;
    end else if (r_state == IDLE && dreq.valid) begin
      r_cnt    <= w_load;
      r_addr   <= dreq.addr;
      r_data   <= dreq.data;
      r_size   <= dreq.size;
      r_strobe <= dreq.strobe;
    end else if (r_state == WAIT) begin
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

  // Out-of-range reads return zero; misaligned reads still return the word.
  always_comb begin
    dresp = '0;
    err   = 1'b0;
    busy  = 1'b0;
    case (r_state)
      WAIT: busy = 1'b1;
      RESP: begin
        busy          = 1'b1;
        dresp.addr_ok = 1'b1;
        dresp.data_ok = 1'b1;
        dresp.data    = w_oor ? 64'h0 : w_rdata;
        err           = w_err;
      end
      default: ;
    endcase
  end

  dbus_sram_array #(.DEPTH(DEPTH)) u_array (
    .clk      (clk),
    .i_we     (w_we),
    .i_idx    (w_idx),
    .i_strobe (r_strobe),
    .i_wdata  (r_data),
    .o_rdata  (w_rdata)
  );

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Randomised self-checking bench for dbus_sram_responder against a word-array
// reference model; honours DBUS_RAND_LAT_EN for the latency expectations.
module tb_dbus_sram_responder;
  import dbus_sram_responder_pkg::*;

  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          NREG  = 32;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [63:0] mdl   [DEPTH];
  bit          known [DEPTH];
  int          latHist [4];

  always #5 clk = ~clk;

  dbus_sram_responder #(
    .DEPTH     (DEPTH),
    .LATENCY   (LAT),
    .BASE_ADDR (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .dreq  (dreq),
    .dresp (dresp),
    .err   (err),
    .busy  (busy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Issues one request, waits for its response and checks it against the model.
  task automatic applyStimulus(input logic [63:0] addr, input msize_t size, input logic [7:0] strobe,
                               input logic [63:0] wdata, output logic [63:0] rdata, output logic rerr);
    int          cyc;
    bit          seen;
    bit          oor;
    bit          mis;
    int          idx;
    int          nbytes;
    logic [63:0] expData;
    rdata = '0;
    rerr  = 1'b0;
    dreq.valid  = 1'b1;
    dreq.addr   = addr;
    dreq.size   = size;
    dreq.strobe = strobe;
    dreq.data   = wdata;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(posedge clk); #1;
      seen = (busy === 1'b1);
    end
    if (!seen) begin
      checkOutput("captureTimeout", 64'd0, 64'd1);
      dreq.valid = 1'b0;
      return;
    end
    cyc = 0;
    while (dresp.data_ok !== 1'b1 && cyc < 16) begin
      @(posedge clk); #1;
      cyc++;
    end
    dreq.valid = 1'b0;
    if (dresp.data_ok !== 1'b1) begin
      checkOutput("respTimeout", 64'd0, 64'd1);
      return;
    end
    rdata = dresp.data;
    rerr  = err;

    nbytes  = 1 << int'(size);
    oor     = (addr < BASE) || (((addr - BASE) / 8) >= 64'(DEPTH));
    mis     = (addr % 64'(nbytes)) != 0;
    idx     = oor ? 0 : int'((addr - BASE) / 8);
    expData = oor ? 64'h0 : mdl[idx];

    checkOutput("addrOk", 64'(dresp.addr_ok), 64'd1);
    checkOutput("err", 64'(err), 64'(oor || mis));
    if (oor || known[idx]) checkOutput("rdata", dresp.data, expData);
`ifdef DBUS_RAND_LAT_EN
    checkOutput("latencyInRange", 64'(cyc >= LAT && cyc <= LAT + 3), 64'd1);
    if (cyc >= LAT && cyc <= LAT + 3) latHist[cyc - LAT]++;
`else
    checkOutput("latency", 64'(cyc), 64'(LAT));
`endif

    if (!oor && !mis && strobe != 8'h00) begin
      for (int b = 0; b < 8; b++) begin
        if (strobe[b]) mdl[idx][8*b +: 8] = wdata[8*b +: 8];
      end
      if (strobe == 8'hFF) known[idx] = 1'b1;
    end
  endtask

  initial begin
    logic [63:0] rd;
    logic [63:0] old;
    logic [63:0] addr;
    logic        re;
    bit          seen;
    bit          sawOk;
    int          r;
    int          nb;
    int          off;
    msize_t      sz;
    logic [7:0]  stb;

    reset = 1'b1;
    dreq  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstDataOk", 64'(dresp.data_ok), 64'd0);
    checkOutput("rstAddrOk", 64'(dresp.addr_ok), 64'd0);
    checkOutput("rstData", dresp.data, 64'd0);
    checkOutput("rstErr", 64'(err), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < NREG; i++)
      applyStimulus(BASE + 64'(8 * i), MSIZE8, 8'hFF, {$urandom, $urandom}, rd, re);

    applyStimulus(BASE + 64'h10, MSIZE8, 8'hFF, 64'h1122334455667788, rd, re);
    applyStimulus(BASE + 64'h10, MSIZE8, 8'h00, 64'h0, rd, re);
    checkOutput("fullWriteRead", rd, 64'h1122334455667788);

    applyStimulus(BASE + 64'h10, MSIZE8, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, rd, re);
    applyStimulus(BASE + 64'h10, MSIZE8, 8'h00, 64'h0, rd, re);
    checkOutput("partialWriteRead", rd, 64'h11223344_BBBBBBBB);

    applyStimulus(64'h7FFF_FFF8, MSIZE8, 8'h00, 64'h0, rd, re);
    checkOutput("oorReadErr", 64'(re), 64'd1);
    checkOutput("oorReadData", rd, 64'd0);

    old = mdl[0];
    applyStimulus(BASE + 64'(DEPTH * 8), MSIZE8, 8'hFF, 64'hDEADBEEF_0BADF00D, rd, re);
    checkOutput("oorWriteErr", 64'(re), 64'd1);
    applyStimulus(BASE, MSIZE8, 8'h00, 64'h0, rd, re);
    checkOutput("oorWriteNoAlias", rd, old);

    applyStimulus(BASE + 64'h4, MSIZE8, 8'hFF, 64'h5555_6666_7777_8888, rd, re);
    checkOutput("misalignErr", 64'(re), 64'd1);
    applyStimulus(BASE, MSIZE8, 8'h00, 64'h0, rd, re);
    checkOutput("misalignNoWrite", rd, old);

    // Reset lands while the write to word 4 is still waiting out its latency.
    old = mdl[4];
    dreq.valid  = 1'b1;
    dreq.addr   = BASE + 64'h20;
    dreq.size   = MSIZE8;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'hCAFEF00D_12345678;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(posedge clk); #1;
      seen = (busy === 1'b1);
    end
    checkOutput("rstCapture", 64'(seen), 64'd1);
    checkOutput("rstInWait", 64'(dresp.data_ok), 64'd0);
    reset      = 1'b1;
    dreq.valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("rstAbortBusy", 64'(busy), 64'd0);
    sawOk = 1'b0;
    repeat (6) begin
      if (dresp.data_ok === 1'b1) sawOk = 1'b1;
      @(posedge clk); #1;
    end
    checkOutput("rstNoDataOk", 64'(sawOk), 64'd0);
    applyStimulus(BASE + 64'h20, MSIZE8, 8'h00, 64'h0, rd, re);
    checkOutput("rstWriteDropped", rd, old);

    for (int n = 0; n < 1000; n++) begin
      r  = int'($urandom_range(0, 99));
      sz = msize_t'($urandom_range(0, 3));
      nb = 1 << int'(sz);
      if (r < 8) begin
        addr = BASE - 64'(8 * $urandom_range(1, 16));
      end else if (r < 16) begin
        addr = BASE + 64'(DEPTH * 8) + 64'(8 * $urandom_range(0, 16));
      end else begin
        if (r < 85) off = int'($urandom_range(0, 8 / nb - 1)) * nb;
        else        off = int'($urandom_range(0, 7));
        addr = BASE + 64'(8 * $urandom_range(0, NREG - 1)) + 64'(off);
      end
      stb = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(1, 255));
      applyStimulus(addr, sz, stb, {$urandom, $urandom}, rd, re);
    end

`ifdef DBUS_RAND_LAT_EN
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("latSeen%0d", LAT + i), 64'(latHist[i] > 0), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dbus_sram_responder.md
Name: dbus_sram_responder

Overview:
- Data-bus responder: the memory side of the dbus_req_t/dbus_resp_t handshake that the core's memory stage and MMU initiate.
- Backs a word-organised SRAM model with a programmable response latency.
- Used in standalone stage/MMU benches and as the on-chip scratch RAM behind the bus fabric.
- Services one request at a time, applies byte-strobed writes, and always returns the full 64-bit word.

Parameters:
- DEPTH, 1024: number of 64-bit words; power of two.
- LATENCY, 2: idle cycles between request capture and response; 0 is legal.
- BASE_ADDR, 64'h8000_0000: byte address of word 0; must be aligned to DEPTH*8.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- dreq  input  dbus_req_t  request: valid, addr[63:0], size (msize_t), strobe[7:0], data[63:0]
- dresp  output  dbus_resp_t  response: addr_ok, data_ok, data[63:0]
- err  output  1  one-cycle pulse coincident with data_ok when the serviced request was out of range or misaligned
- busy  output  1  high in WAIT and RESP

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk.
  - FSM goes to IDLE; counter = 0.
  - addr_ok = 0, data_ok = 0, data = 0, err = 0, busy = 0.
  - SRAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If dreq.valid is high, latch addr, size, strobe and data at the clock edge.
  - Load the counter with LATENCY.
  - Go to WAIT, or directly to RESP when LATENCY = 0.
- WAIT: decrement the counter each cycle; go to RESP when the counter reaches 1.
- RESP (exactly one cycle):
  - addr_ok = data_ok = 1.
  - data = mem[idx], where idx = (addr - BASE_ADDR) >> 3.
  - Write commits at the closing edge: for each i with strobe[i] set, byte i of mem[idx] takes byte i of data.
  - Next state is IDLE.
- Latency: a request captured at the edge ending cycle T gets its response during cycle T+1+LATENCY.
- Read data: combinational from the array in RESP, and holds the pre-write value on a write.
- Write vs read: strobe == 0 means read; any nonzero strobe means write.
- Handshake: the initiator holds dreq stable until it sees data_ok.
  - After RESP the block is in IDLE. If valid is still high that cycle, it is taken as a new request.
  - Back-to-back throughput is therefore one request per LATENCY+2 cycles.
- Errors are flagged with err during RESP, and data_ok still asserts (no hang):
  - Out of range: addr < BASE_ADDR or idx >= DEPTH. Read data = 0 and the write is dropped.
  - Misaligned: addr not aligned to the size encoded in msize_t. The write is dropped; read data is returned normally.
- dreq.valid dropping while in WAIT: the transaction completes anyway and the response is still pulsed.
- Reset mid-transaction: abort to IDLE and drop any pending write.

Optional Feature:
- Macro: DBUS_RAND_LAT_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16, 14, 13, 11; seed 16'hACE1 at reset) advances every cycle.
  - On capture, the counter is loaded with LATENCY + lfsr[1:0], giving latency LATENCY to LATENCY+3.
- Undefined: latency is exactly LATENCY and no LFSR logic is present.

Decomposition:
- dbus_req_t, dbus_resp_t and msize_t come from the existing common package.
- Add to that package:
  - a resp_state_t enum (IDLE/WAIT/RESP);
  - the function msize_align_ok(addr, size).
- One natural sub-module: dbus_sram_array, a DEPTH x 64 array with byte write-enable, an asynchronous read port, and one synchronous write port. The FSM stays in the top.

Test Plan:
- LATENCY=2: write addr 8000_0010, strobe FF, data 1122334455667788, then read the same address -> data_ok 3 cycles after capture and read data 1122334455667788.
- Partial write: strobe 0F, data AAAAAAAA_BBBBBBBB to the same word -> read returns 11223344_BBBBBBBB.
- Out of range: read addr 7FFF_FFF8 -> data_ok with err = 1 and data = 0; write to 8000_0000 + DEPTH*8 -> err = 1 and no word changed.
- Misaligned: doubleword write at 8000_0004 -> err = 1 and memory unchanged.
- Reset asserted in WAIT during a write to 8000_0020 -> no data_ok, FSM in IDLE, and a subsequent read returns the old value.
- With DBUS_RAND_LAT_EN: issue 1000 back-to-back reads -> every latency falls in [LATENCY, LATENCY+3], all four values are seen, and data is correct throughout.
